// File: rtl/hdmi_packet_pkg.sv
// Shared packet header codes and InfoFrame pending mask for the HDMI data-island scheduler.
// HDMI_SPD_INFOFRAME_EN adds the SPD InfoFrame bit to the pending mask.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL         = 8'h00;
  localparam logic [7:0] PKT_ACR          = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
  localparam logic [7:0] PKT_AVI          = 8'h82;
  localparam logic [7:0] PKT_SPD          = 8'h83;
  localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

`ifdef HDMI_SPD_INFOFRAME_EN
  typedef struct packed {
    logic avi;
    logic aud;
    logic spd;
  } pending_t;
`else
  typedef struct packed {
    logic avi;
    logic aud;
  } pending_t;
`endif

endpackage

// File: rtl/packet_priority_select.sv
// Combinational first-match selector: ACR, AVI, Audio InfoFrame, SPD (HDMI_SPD_INFOFRAME_EN), audio, null.
module packet_priority_select
  import hdmi_packet_pkg::*;
(
  input  logic       acr_owed,
  input  pending_t   pending,
  input  logic       audio_ready,
  output logic [7:0] sel_type,
  output logic       acr_take,
  output pending_t   clear,
  output logic       pop
);

  always_comb begin
    sel_type = PKT_NULL;
    acr_take = 1'b0;
    clear    = '0;
    pop      = 1'b0;
    if (acr_owed) begin
      sel_type = PKT_ACR;
      acr_take = 1'b1;
    end else if (pending.avi) begin
      sel_type  = PKT_AVI;
      clear.avi = 1'b1;
    end else if (pending.aud) begin
      sel_type  = PKT_AUDIO_IF;
      clear.aud = 1'b1;
    end
`ifdef HDMI_SPD_INFOFRAME_EN
    else if (pending.spd) begin
      sel_type  = PKT_SPD;
      clear.spd = 1'b1;
    end
`endif
    else if (audio_ready) begin
      sel_type = PKT_AUDIO_SAMPLE;
      pop      = 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Per-frame data-island packet scheduler in the pixel domain (ACR, InfoFrames, audio, null).
// HDMI_SPD_INFOFRAME_EN enables the SPD InfoFrame (0x83) after the Audio InfoFrame.
module hdmi_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned REMAINING_WIDTH          = 8,
  parameter int unsigned AUDIO_SAMPLES_PER_PACKET = 1,
  parameter int unsigned ACR_PER_FRAME            = 1,
  parameter int unsigned INFOFRAME_PERIOD         = 1,
  parameter int unsigned AVI_INFOFRAME            = 1,
  parameter int unsigned AUDIO_INFOFRAME          = 1
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       packet_enable,
  input  logic [REMAINING_WIDTH-1:0] audio_remaining,
  output logic [7:0]                 packet_type,
  output logic                       audio_pop,
  output logic [2:0]                 audio_pop_count
);

  localparam logic [3:0] ACR_LOAD  = 4'(ACR_PER_FRAME);
  localparam logic [7:0] DIV_LAST  = 8'(INFOFRAME_PERIOD - 1);
  localparam logic [2:0] POP_COUNT = 3'(AUDIO_SAMPLES_PER_PACKET);
  localparam logic [REMAINING_WIDTH-1:0] AUDIO_NEED = REMAINING_WIDTH'(AUDIO_SAMPLES_PER_PACKET);

  logic [3:0] acr_left;
  pending_t   pending;
  logic [7:0] frame_div;

  pending_t   enabled;
  logic [7:0] div_next;
  logic [3:0] acr_eff;
  pending_t   pend_eff;
  logic       audio_ready;

  logic [7:0] sel_type;
  logic       acr_take;
  pending_t   clear;
  logic       pop;

  always_comb begin
    enabled     = '0;
    enabled.avi = (AVI_INFOFRAME != 0);
    enabled.aud = (AUDIO_INFOFRAME != 0);
`ifdef HDMI_SPD_INFOFRAME_EN
    enabled.spd = 1'b1;
`endif
  end

  // A coincident frame_start is folded in before selection so the new frame's first ACR goes out in this slot.
  always_comb begin
    div_next = (frame_div >= DIV_LAST) ? 8'd0 : frame_div + 8'd1;
    acr_eff  = frame_start ? ACR_LOAD : acr_left;
    pend_eff = pending;
    if (frame_start && (div_next == 8'd0)) begin
      pend_eff = enabled;
    end
  end

  assign audio_ready = (audio_remaining >= AUDIO_NEED);

  packet_priority_select u_select (
    .acr_owed    (acr_eff != 4'd0),
    .pending     (pend_eff),
    .audio_ready (audio_ready),
    .sel_type    (sel_type),
    .acr_take    (acr_take),
    .clear       (clear),
    .pop         (pop)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_left        <= 4'd0;
      pending         <= '0;
      frame_div       <= DIV_LAST;
      packet_type     <= PKT_NULL;
      audio_pop       <= 1'b0;
      audio_pop_count <= 3'd0;
    end else begin
      if (frame_start) begin
        frame_div <= div_next;
      end
      audio_pop       <= 1'b0;
      audio_pop_count <= 3'd0;
      if (packet_enable) begin
        packet_type     <= sel_type;
        acr_left        <= acr_take ? (acr_eff - 4'd1) : acr_eff;
        pending         <= pending_t'(pend_eff & ~clear);
        audio_pop       <= pop;
        audio_pop_count <= pop ? POP_COUNT : 3'd0;
      end else begin
        acr_left <= acr_eff;
        pending  <= pend_eff;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Bench for hdmi_packet_scheduler: five parameterisations share one stimulus stream against a frame-level model.
module tb_hdmi_packet_scheduler;

  localparam int NI = 5;
  // Instance roles: 0 defaults, 1 ACR=3 no IF, 2 period 2, 3 four samples no IF, 4 ACR=2.
  localparam int C_APP[NI] = '{1, 1, 1, 4, 1};
  localparam int C_ACR[NI] = '{1, 3, 1, 1, 2};
  localparam int C_PER[NI] = '{1, 1, 2, 1, 1};
  localparam int C_AVI[NI] = '{1, 0, 1, 0, 1};
  localparam int C_AUD[NI] = '{1, 0, 1, 0, 1};
`ifdef HDMI_SPD_INFOFRAME_EN
  localparam bit SPD_ON = 1'b1;
`else
  localparam bit SPD_ON = 1'b0;
`endif
  localparam logic [7:0] T_END = SPD_ON ? 8'h83 : 8'h00;
  localparam logic [7:0] P1_LAST = SPD_ON ? 8'h83 : 8'h02;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       packet_enable = 1'b0;
  logic [7:0] audio_remaining = 8'd0;

  logic [7:0] d_type [NI];
  logic       d_pop  [NI];
  logic [2:0] d_cnt  [NI];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hdmi_packet_scheduler #(.AUDIO_SAMPLES_PER_PACKET(1), .ACR_PER_FRAME(1), .INFOFRAME_PERIOD(1),
    .AVI_INFOFRAME(1), .AUDIO_INFOFRAME(1)) u_dut0 (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start), .packet_enable(packet_enable),
    .audio_remaining(audio_remaining), .packet_type(d_type[0]), .audio_pop(d_pop[0]),
    .audio_pop_count(d_cnt[0]));
  hdmi_packet_scheduler #(.AUDIO_SAMPLES_PER_PACKET(1), .ACR_PER_FRAME(3), .INFOFRAME_PERIOD(1),
    .AVI_INFOFRAME(0), .AUDIO_INFOFRAME(0)) u_dut1 (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start), .packet_enable(packet_enable),
    .audio_remaining(audio_remaining), .packet_type(d_type[1]), .audio_pop(d_pop[1]),
    .audio_pop_count(d_cnt[1]));
  hdmi_packet_scheduler #(.AUDIO_SAMPLES_PER_PACKET(1), .ACR_PER_FRAME(1), .INFOFRAME_PERIOD(2),
    .AVI_INFOFRAME(1), .AUDIO_INFOFRAME(1)) u_dut2 (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start), .packet_enable(packet_enable),
    .audio_remaining(audio_remaining), .packet_type(d_type[2]), .audio_pop(d_pop[2]),
    .audio_pop_count(d_cnt[2]));
  hdmi_packet_scheduler #(.AUDIO_SAMPLES_PER_PACKET(4), .ACR_PER_FRAME(1), .INFOFRAME_PERIOD(1),
    .AVI_INFOFRAME(0), .AUDIO_INFOFRAME(0)) u_dut3 (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start), .packet_enable(packet_enable),
    .audio_remaining(audio_remaining), .packet_type(d_type[3]), .audio_pop(d_pop[3]),
    .audio_pop_count(d_cnt[3]));
  hdmi_packet_scheduler #(.AUDIO_SAMPLES_PER_PACKET(1), .ACR_PER_FRAME(2), .INFOFRAME_PERIOD(1),
    .AVI_INFOFRAME(1), .AUDIO_INFOFRAME(1)) u_dut4 (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start), .packet_enable(packet_enable),
    .audio_remaining(audio_remaining), .packet_type(d_type[4]), .audio_pop(d_pop[4]),
    .audio_pop_count(d_cnt[4]));

  // Model: owed ACR count, owed InfoFrame flags, frames seen since reset.
  int         m_acr    [NI];
  bit         m_avi    [NI];
  bit         m_aud    [NI];
  bit         m_spd    [NI];
  int         m_frames [NI];
  logic [7:0] e_type   [NI];
  logic       e_pop    [NI];
  logic [2:0] e_cnt    [NI];
  bit         e_new = 1'b0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      e_type[i] = 8'h00;
      e_pop[i]  = 1'b0;
      e_cnt[i]  = 3'd0;
    end
    forever begin
      @(posedge clk);
      e_new = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (reset) begin
          m_acr[i] = 0; m_avi[i] = 0; m_aud[i] = 0; m_spd[i] = 0; m_frames[i] = 0;
          e_type[i] = 8'h00; e_pop[i] = 1'b0; e_cnt[i] = 3'd0;
        end else begin
          if (frame_start) begin
            m_acr[i] = C_ACR[i];
            if ((m_frames[i] % C_PER[i]) == 0) begin
              m_avi[i] = (C_AVI[i] != 0);
              m_aud[i] = (C_AUD[i] != 0);
              m_spd[i] = SPD_ON;
            end
            m_frames[i]++;
          end
          e_pop[i] = 1'b0;
          e_cnt[i] = 3'd0;
          if (packet_enable) begin
            e_new = 1'b1;
            if (m_acr[i] > 0) begin
              e_type[i] = 8'h01; m_acr[i]--;
            end else if (m_avi[i]) begin
              e_type[i] = 8'h82; m_avi[i] = 0;
            end else if (m_aud[i]) begin
              e_type[i] = 8'h84; m_aud[i] = 0;
            end else if (m_spd[i]) begin
              e_type[i] = 8'h83; m_spd[i] = 0;
            end else if (int'(audio_remaining) >= C_APP[i]) begin
              e_type[i] = 8'h02; e_pop[i] = 1'b1; e_cnt[i] = 3'(C_APP[i]);
            end else begin
              e_type[i] = 8'h00;
            end
          end
        end
      end
    end
  end

  // Per-instance log of what the DUT issued after each packet_enable.
  logic [7:0] log_t [NI][16];
  logic [2:0] log_c [NI][16];
  int         log_n [NI];

  initial begin
    for (int i = 0; i < NI; i++) log_n[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (d_type[i] !== e_type[i]) begin
          n_fail++;
          $display("FAIL packet_type[%0d] t=%0t: got %h want %h", i, $time, d_type[i], e_type[i]);
        end
        n_checks++;
        if (d_pop[i] !== e_pop[i]) begin
          n_fail++;
          $display("FAIL audio_pop[%0d] t=%0t: got %b want %b", i, $time, d_pop[i], e_pop[i]);
        end
        n_checks++;
        if (d_cnt[i] !== e_cnt[i]) begin
          n_fail++;
          $display("FAIL audio_pop_count[%0d] t=%0t: got %0d want %0d", i, $time, d_cnt[i], e_cnt[i]);
        end
        if (e_new) begin
          if (log_n[i] < 16) begin
            log_t[i][log_n[i]] = d_type[i];
            log_c[i][log_n[i]] = d_cnt[i];
          end
          log_n[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic pe, input logic [7:0] aud);
    frame_start = fs;
    packet_enable = pe;
    audio_remaining = aud;
    tick();
    frame_start = 1'b0;
    packet_enable = 1'b0;
  endtask

  task automatic pulses(input int n, input logic [7:0] aud);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, aud);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic clear_logs();
    tick();
    tick();
    for (int i = 0; i < NI; i++) log_n[i] = 0;
  endtask

  task automatic check_seq(input int inst, input int n, input logic [127:0] w, input string name);
    logic [7:0] want;
    tick();
    tick();
    n_checks++;
    if (log_n[inst] != n) begin
      n_fail++;
      $display("FAIL %s length: got %0d want %0d", name, log_n[inst], n);
    end
    for (int i = 0; i < n; i++) begin
      want = w[8*(n-1-i) +: 8];
      n_checks++;
      if (log_t[inst][i] !== want) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h want %h", name, i, log_t[inst][i], want);
      end
    end
  endtask

  task automatic check_cnt(input int inst, input int idx, input logic [2:0] want, input string name);
    n_checks++;
    if (log_c[inst][idx] !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, log_c[inst][idx], want);
    end
  endtask

  initial begin
    // Reset state pinned directly.
    do_reset();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (d_type[i] !== 8'h00 || d_pop[i] !== 1'b0 || d_cnt[i] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h/%b/%0d want 00/0/0", i, d_type[i], d_pop[i], d_cnt[i]);
      end
    end

    // Defaults: ACR, AVI, Audio IF, then audio.
    clear_logs();
    drive(1'b1, 1'b0, 8'd3);
    pulses(4, 8'd3);
    check_seq(0, 4, {8'h01, 8'h82, 8'h84, P1_LAST}, "defaults_seq");
    check_cnt(0, 3, SPD_ON ? 3'd0 : 3'd1, "defaults_pop_count");

    // Three ACR per frame then nulls.
    do_reset();
    clear_logs();
    drive(1'b1, 1'b0, 8'd0);
    pulses(5, 8'd0);
    check_seq(1, 5, {8'h01, 8'h01, 8'h01, T_END == 8'h83 ? 8'h83 : 8'h00, 8'h00}, "acr3_seq");

    // InfoFrame period 2 over three frames.
    do_reset();
    clear_logs();
    for (int f = 0; f < 3; f++) begin
      drive(1'b1, 1'b0, 8'd0);
      pulses(4, 8'd0);
    end
    check_seq(2, 12, {8'h01, 8'h82, 8'h84, T_END, 8'h01, 8'h00, 8'h00, 8'h00,
                      8'h01, 8'h82, 8'h84, T_END}, "period2_seq");

    // Four samples per packet: 3 in buffer is not enough, 4 is.
    do_reset();
    clear_logs();
    drive(1'b1, 1'b0, 8'd0);
    pulses(2, 8'd0);
    pulses(1, 8'd3);
    pulses(1, 8'd4);
    check_seq(3, 4, {8'h01, T_END, 8'h00, 8'h02}, "app4_seq");
    check_cnt(3, 3, 3'd4, "app4_pop_count");

    // frame_start coincident with packet_enable after ACR spent.
    do_reset();
    clear_logs();
    drive(1'b1, 1'b0, 8'd0);
    pulses(5, 8'd0);
    drive(1'b1, 1'b1, 8'd0);
    pulses(2, 8'd0);
    check_seq(4, 8, {8'h01, 8'h01, 8'h82, 8'h84, T_END, 8'h01, 8'h01, 8'h82}, "coincident_seq");

    // Mid-frame reset drops the pending AVI until the next frame.
    do_reset();
    clear_logs();
    drive(1'b1, 1'b0, 8'd0);
    pulses(1, 8'd0);
    do_reset();
    pulses(3, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    pulses(4, 8'd0);
    check_seq(0, 8, {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h82, 8'h84, T_END}, "midreset_seq");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
